vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//   Source end of the pixel-coordinate interface: generates HCount/VCount, sync and blanking
//   for 640x480@60Hz VGA. Card/tile renderers consume HCount/VCount combinationally and return
//   rgb_in; this block registers that rgb, blanks it and aligns it with the sync pins.
//   Sits between the board clock and the VGA connector, one instance per display.
// PARAMETERS
//   CLK_DIV    2    system clocks per pixel (2 -> 25 MHz pixel from 50 MHz clk); >=1
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch, pixels
//   H_SYNC     96   horizontal sync width, pixels
//   H_BACK     48   horizontal back porch, pixels
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch, lines
//   V_SYNC     2    vertical sync width, lines
//   V_BACK     33   vertical back porch, lines
//   SYNC_POL   0    sync active level (0 = active-low)
// PORTS
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   pix_tick   out  1   one-clk strobe; counters advance on the clk edge where it is high
//   HCount     out  10  current pixel column, 0..H_TOTAL-1
//   VCount     out  10  current line, 0..V_TOTAL-1
//   video_on   out  1   HCount<H_DISPLAY && VCount<V_DISPLAY (same cycle as counters)
//   frame_tick out  1   one-clk pulse when counters wrap to (0,0)
//   rgb_in     in   3   pixel colour from renderers, for current HCount/VCount
//   hsync      out  1   registered horizontal sync, aligned with rgb
//   vsync      out  1   registered vertical sync, aligned with rgb
//   rgb        out  3   registered, blanked pixel colour
// BEHAVIOUR
//   H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
//   Reset (sync, dominates everything): div counter, HCount, VCount, rgb = 0; pix_tick,
//     frame_tick = 0; hsync, vsync = ~SYNC_POL; video_on = 1 (counters at 0,0).
//   Divider: div_cnt counts 0..CLK_DIV-1; pix_tick = (div_cnt==CLK_DIV-1), registered so it
//     is high for exactly one clk per pixel; CLK_DIV=1 -> pix_tick high every clk after reset.
//     First pix_tick occurs CLK_DIV clks after reset deasserts.
//   Counters update only on pix_tick: HCount==H_TOTAL-1 -> HCount=0 and VCount advances;
//     VCount==V_TOTAL-1 on that wrap -> VCount=0. No other wrap points.
//   frame_tick: high for the one clk following the pix_tick edge that moves (799,524)->(0,0).
//   video_on: combinational from registered HCount/VCount; no glitch-free requirement beyond that.
//   Output stage (1-pixel latency, updates only on pix_tick):
//     rgb   <= video_on ? rgb_in : 3'b000
//     hsync <= (HCount in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]) ? SYNC_POL : ~SYNC_POL
//     vsync <= (VCount in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]) ? SYNC_POL : ~SYNC_POL
//     i.e. pins reflect the pixel at the previous HCount/VCount; all three stay mutually aligned.
//   Between pix_ticks every output holds its value.
//   Reset mid-frame: next clk all state as above; timing restarts from (0,0) with no partial
//     sync pulse carried over.
//   rgb_in ignored outside visible area; X on rgb_in during blanking must not reach rgb.
// TESTING
//   1 Reset 5 clks, release, CLK_DIV=2 -> pix_tick first high 2 clks later, then every 2nd clk;
//     HCount 0->1 on first tick.
//   2 Run one line -> HCount reaches 799 then 0, VCount 0->1; hsync low for exactly 96 ticks,
//     first low pixel-slot is the one after HCount=656 sampled; 800 ticks per line.
//   3 Run full frame -> vsync low for exactly 2 lines (VCount 490,491 + 1 px latency),
//     frame_tick one pulse per 420000 pix_ticks; VCount never exceeds 524.
//   4 Drive rgb_in=3'b111 constant -> rgb=111 only for pixels with HCount<640, VCount<480
//     (one tick later); rgb=000 in all blanking, including HCount=640 and VCount=480.
//   5 Assert reset at HCount=700, VCount=490 (inside vsync) -> next clk HCount=VCount=0,
//     hsync=vsync=1, rgb=0; following frame timing identical to scenario 3.
//   6 CLK_DIV=1 instance -> pix_tick continuously high; line length 800 clks; frame 420000 clks.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Pixel-coordinate interface between the VGA timing source and the renderers.
// The timing source drives the coordinates and strobes; renderers return rgb_in
// combinationally for the current HCount/VCount.
interface vga_sync_gen_if;
    logic       pix_tick;
    logic [9:0] HCount;
    logic [9:0] VCount;
    logic       video_on;
    logic       frame_tick;
    logic [2:0] rgb_in;

    modport master (
        output pix_tick,
        output HCount,
        output VCount,
        output video_on,
        output frame_tick,
        input  rgb_in
    );

    modport slave (
        input  pix_tick,
        input  HCount,
        input  VCount,
        input  video_on,
        input  frame_tick,
        output rgb_in
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, HCount/VCount raster counters,
// and a one-pixel-latency output stage that registers sync and blanked colour
// so the connector pins stay mutually aligned.
module vga_sync_gen #(
    parameter int   CLK_DIV   = 2,
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_sync_gen_if.master        pix,
    output logic                  hsync,
    output logic                  vsync,
    output logic [2:0]            rgb
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS        = 10'(H_DISPLAY);
    localparam logic [9:0]       V_VIS        = 10'(V_DISPLAY);
    localparam logic [9:0]       H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]       H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]       V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]       V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_tick_q, pix_tick_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic             frame_tick_q, frame_tick_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [2:0]       rgb_q, rgb_d;
    logic             video_on;

    // Visible area decode straight off the registered counters.
    assign video_on = (hcount_q < H_VIS) && (vcount_q < V_VIS);

    // Pixel-rate divider: the tick is registered so it is a clean one-clk strobe.
    always_comb begin
        div_d      = div_q;
        pix_tick_d = (div_q == DIV_LAST);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Raster counters and output stage; everything holds between pixel ticks.
    always_comb begin
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        frame_tick_d = 1'b0;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        rgb_d        = rgb_q;
        if (pix_tick_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d     = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
            // Gate with the visible flag so blanking never passes renderer data (or X).
            rgb_d   = video_on ? pix.rgb_in : 3'b000;
            hsync_d = ((hcount_q >= H_SYNC_FIRST) && (hcount_q <= H_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
            vsync_d = ((vcount_q >= V_SYNC_FIRST) && (vcount_q <= V_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
        end
    end

    // State register; reset restarts the raster from (0,0) with sync inactive.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            pix_tick_q   <= 1'b0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            frame_tick_q <= 1'b0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            rgb_q        <= 3'b000;
        end else begin
            div_q        <= div_d;
            pix_tick_q   <= pix_tick_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            frame_tick_q <= frame_tick_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            rgb_q        <= rgb_d;
        end
    end

    assign pix.pix_tick   = pix_tick_q;
    assign pix.HCount     = hcount_q;
    assign pix.VCount     = vcount_q;
    assign pix.video_on   = video_on;
    assign pix.frame_tick = frame_tick_q;
    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign rgb            = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance (CLK_DIV=2) plus two
// shrunken-raster instances (CLK_DIV=2 and CLK_DIV=1) so whole frames fit in a
// short run. A closed-form raster model predicts every output each clock.
module tb_vga_sync_gen;

    typedef struct {
        int d;
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
    } cfg_t;

    typedef struct {
        int k;      // clocks since reset released
        int h;
        int v;
        bit pt;
        bit hs;
        bit vo;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [3];

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();
    vga_sync_gen_if if_c ();

    logic       hs_o [3];
    logic       vs_o [3];
    logic [2:0] rgb_o [3];

    vga_sync_gen u_a (
        .clk   (clk),
        .reset (rst[0]),
        .pix   (if_a),
        .hsync (hs_o[0]),
        .vsync (vs_o[0]),
        .rgb   (rgb_o[0])
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
    ) u_b (
        .clk   (clk),
        .reset (rst[1]),
        .pix   (if_b),
        .hsync (hs_o[1]),
        .vsync (vs_o[1]),
        .rgb   (rgb_o[1])
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
    ) u_c (
        .clk   (clk),
        .reset (rst[2]),
        .pix   (if_c),
        .hsync (hs_o[2]),
        .vsync (vs_o[2]),
        .rgb   (rgb_o[2])
    );

    logic [9:0] h_o [3];
    logic [9:0] v_o [3];
    logic       pt_o [3];
    logic       vo_o [3];
    logic       ft_o [3];
    assign h_o[0] = if_a.HCount;   assign h_o[1] = if_b.HCount;   assign h_o[2] = if_c.HCount;
    assign v_o[0] = if_a.VCount;   assign v_o[1] = if_b.VCount;   assign v_o[2] = if_c.VCount;
    assign pt_o[0] = if_a.pix_tick; assign pt_o[1] = if_b.pix_tick; assign pt_o[2] = if_c.pix_tick;
    assign vo_o[0] = if_a.video_on; assign vo_o[1] = if_b.video_on; assign vo_o[2] = if_c.video_on;
    assign ft_o[0] = if_a.frame_tick; assign ft_o[1] = if_b.frame_tick; assign ft_o[2] = if_c.frame_tick;

    cfg_t cfg [3];
    int   mk  [3];          // model: clock edges since reset released
    int   erg [3];          // model: expected rgb pins
    bit   ehs [3];
    bit   evs [3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c_rst_at = 0;
    int c_rst_len = 1;
    bit b_done   = 1'b0;
    int b_vmax   = 0;

    function automatic int ht(cfg_t c);
        return c.hd + c.hf + c.hs + c.hb;
    endfunction

    function automatic int vt(cfg_t c);
        return c.vd + c.vf + c.vs + c.vb;
    endfunction

    // Number of pixel ticks consumed after k clock edges out of reset.
    function automatic int ticks(cfg_t c, int k);
        return (k >= 1) ? (k - 1) / c.d : 0;
    endfunction

    // pix_tick level after k clock edges out of reset.
    function automatic bit ptick(cfg_t c, int k);
        return (k >= c.d) && (k % c.d == 0);
    endfunction

    task automatic chk(int i, string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL inst%0d %s at k=%0d: got %0d expected %0d", i, nm, mk[i], act, exp);
        end
    endtask

    // Advance the model across one clock edge with the inputs the DUT sampled.
    task automatic model_edge(int i, bit r, logic [2:0] rin);
        int ft, p, h, v;
        if (r) begin
            mk[i]  = 0;
            erg[i] = 0;
            ehs[i] = 1'b1;
            evs[i] = 1'b1;
        end else begin
            if (ptick(cfg[i], mk[i])) begin
                ft = ht(cfg[i]) * vt(cfg[i]);
                p  = ticks(cfg[i], mk[i]) % ft;
                h  = p % ht(cfg[i]);
                v  = p / ht(cfg[i]);
                erg[i] = (h < cfg[i].hd && v < cfg[i].vd) ? int'(rin) : 0;
                ehs[i] = !(h >= cfg[i].hd + cfg[i].hf && h < cfg[i].hd + cfg[i].hf + cfg[i].hs);
                evs[i] = !(v >= cfg[i].vd + cfg[i].vf && v < cfg[i].vd + cfg[i].vf + cfg[i].vs);
            end
            mk[i]++;
        end
    endtask

    task automatic check_inst(int i);
        int t, ft, p, h, v;
        bit eft;
        t   = ticks(cfg[i], mk[i]);
        ft  = ht(cfg[i]) * vt(cfg[i]);
        p   = t % ft;
        h   = p % ht(cfg[i]);
        v   = p / ht(cfg[i]);
        eft = (mk[i] >= 1) && ptick(cfg[i], mk[i] - 1) && (t > 0) && (t % ft == 0);
        chk(i, "HCount", int'(h_o[i]), h);
        chk(i, "VCount", int'(v_o[i]), v);
        chk(i, "pix_tick", int'(pt_o[i]), int'(ptick(cfg[i], mk[i])));
        chk(i, "video_on", int'(vo_o[i]), int'(h < cfg[i].hd && v < cfg[i].vd));
        chk(i, "frame_tick", int'(ft_o[i]), int'(eft));
        chk(i, "hsync", int'(hs_o[i]), int'(ehs[i]));
        chk(i, "vsync", int'(vs_o[i]), int'(evs[i]));
        chk(i, "rgb", int'(rgb_o[i]), erg[i]);
    endtask

    // One clock: choose inputs, clock, update model, check on the falling edge.
    task automatic step();
        logic [2:0] rin [3];
        bit b_hit;
        int pb;
        b_hit = 1'b0;
        // Mid-frame reset of the small CLK_DIV=2 raster at (28,10): back porch, inside vsync.
        if (!b_done && !rst[1]) begin
            pb = ticks(cfg[1], mk[1]) % (ht(cfg[1]) * vt(cfg[1]));
            if (pb == 10 * ht(cfg[1]) + 28) begin
                chk(1, "vsync_before_reset", int'(vs_o[1]), 0);
                rst[1] = 1'b1;
                b_hit  = 1'b1;
            end
        end
        if (cyc == c_rst_at) rst[2] = 1'b1;
        if (cyc == c_rst_at + c_rst_len) rst[2] = 1'b0;

        rin[0] = 3'b111;
        rin[1] = 3'($urandom);
        rin[2] = 3'($urandom);
        if_a.rgb_in = rin[0];
        if_b.rgb_in = rin[1];
        if_c.rgb_in = rin[2];

        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i, rst[i], rin[i]);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) check_inst(i);
        if (!rst[1] && int'(v_o[1]) > b_vmax) b_vmax = int'(v_o[1]);

        if (b_hit) begin
            chk(1, "reset_HCount", int'(h_o[1]), 0);
            chk(1, "reset_VCount", int'(v_o[1]), 0);
            chk(1, "reset_hsync", int'(hs_o[1]), 1);
            chk(1, "reset_vsync", int'(vs_o[1]), 1);
            chk(1, "reset_rgb", int'(rgb_o[1]), 0);
            rst[1] = 1'b0;
            b_done = 1'b1;
        end
    endtask

    initial begin
        vec_t tbl [14];
        int   guard;

        cfg[0] = '{d:2, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33};
        cfg[1] = '{d:2, hd:16, hf:4, hs:6, hb:4, vd:8, vf:2, vs:2, vb:3};
        cfg[2] = '{d:1, hd:16, hf:4, hs:6, hb:4, vd:8, vf:2, vs:2, vb:3};

        // Full-size raster, CLK_DIV=2: {k, HCount, VCount, pix_tick, hsync, video_on}
        tbl[0]  = '{k:0,    h:0,   v:0, pt:0, hs:1, vo:1};
        tbl[1]  = '{k:1,    h:0,   v:0, pt:0, hs:1, vo:1};
        tbl[2]  = '{k:2,    h:0,   v:0, pt:1, hs:1, vo:1};
        tbl[3]  = '{k:3,    h:1,   v:0, pt:0, hs:1, vo:1};
        tbl[4]  = '{k:4,    h:1,   v:0, pt:1, hs:1, vo:1};
        tbl[5]  = '{k:1279, h:639, v:0, pt:0, hs:1, vo:1};
        tbl[6]  = '{k:1281, h:640, v:0, pt:0, hs:1, vo:0};
        tbl[7]  = '{k:1313, h:656, v:0, pt:0, hs:1, vo:0};
        tbl[8]  = '{k:1315, h:657, v:0, pt:0, hs:0, vo:0};
        tbl[9]  = '{k:1505, h:752, v:0, pt:0, hs:0, vo:0};
        tbl[10] = '{k:1507, h:753, v:0, pt:0, hs:1, vo:0};
        tbl[11] = '{k:1599, h:799, v:0, pt:0, hs:1, vo:0};
        tbl[12] = '{k:1601, h:0,   v:1, pt:0, hs:1, vo:1};
        tbl[13] = '{k:1602, h:0,   v:1, pt:1, hs:1, vo:1};

        c_rst_at  = $urandom_range(1500, 3000);
        c_rst_len = $urandom_range(1, 3);

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            mk[i]  = 0;
            erg[i] = 0;
            ehs[i] = 1'b1;
            evs[i] = 1'b1;
        end
        if_a.rgb_in = 3'b000;
        if_b.rgb_in = 3'b000;
        if_c.rgb_in = 3'b000;

        for (int n = 0; n < 5; n++) step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        rst[2] = 1'b0;

        // Reset-state check before the first released edge.
        chk(0, "reset_video_on", int'(vo_o[0]), 1);
        chk(0, "reset_hsync", int'(hs_o[0]), 1);

        for (int e = 0; e < 14; e++) begin
            guard = 0;
            while (mk[0] < tbl[e].k && guard < 4000) begin
                step();
                guard++;
            end
            chk(0, "tbl_reached", mk[0], tbl[e].k);
            chk(0, "tbl_HCount", int'(h_o[0]), tbl[e].h);
            chk(0, "tbl_VCount", int'(v_o[0]), tbl[e].v);
            chk(0, "tbl_pix_tick", int'(pt_o[0]), int'(tbl[e].pt));
            chk(0, "tbl_hsync", int'(hs_o[0]), int'(tbl[e].hs));
            chk(0, "tbl_video_on", int'(vo_o[0]), int'(tbl[e].vo));
        end

        while (cyc < 4500) step();

        chk(1, "mid_frame_reset_done", int'(b_done), 1);
        chk(1, "VCount_max", b_vmax, vt(cfg[1]) - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
